// File: rtl/om_blend_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// om_blend_rmw_ctrl
//   Read-modify-write front end for the OM blender. Fragments (address,
//   source colour) are accepted when the framebuffer read is issued. The
//   returning destination colour is parked in a pending FIFO. Ready
//   source/destination pairs are then fed to the 3-stage blender. The
//   blended colour is written back to the same address.
//   A request whose address matches any in-flight fragment (FIFO or blend
//   stage) is held off, which keeps RMW ordering per address.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   req_*               fragment request (valid/ready, addr, colour)
//   mem_rd_*            framebuffer read request (valid/ready, addr)
//   mem_rsp_*           in-order read data, no backpressure
//   blend_*             blender enable, src/dst colours out, result in
//   mem_wr_*            write-back (valid/ready, addr, data)
//   busy                any FIFO entry or blend stage occupied
// ---------------------------------------------------------------------------
module om_blend_rmw_ctrl #(
  parameter int ADDRW         = 24,
  parameter int OUTSTANDING   = 4,
  parameter int BLEND_LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [31:0]      req_color,
  output logic             req_ready,
  output logic             mem_rd_valid,
  output logic [ADDRW-1:0] mem_rd_addr,
  input  logic             mem_rd_ready,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             blend_enable,
  output logic [31:0]      blend_src_color,
  output logic [31:0]      blend_dst_color,
  input  logic [31:0]      blend_color_in,
  output logic             mem_wr_valid,
  output logic [ADDRW-1:0] mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  input  logic             mem_wr_ready,
  output logic             busy
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_FULL  = CW'(OUTSTANDING);
  localparam logic [CW-1:0] LP_CONE  = CW'(1);
  localparam logic [CW-1:0] LP_CZERO = CW'(0);
  localparam logic [PW-1:0] LP_PONE  = PW'(1);

  // The pipeline below is hard-wired to three enabled stages.
  if (BLEND_LATENCY != 3) begin : g_bad_latency
    $error("om_blend_rmw_ctrl: only BLEND_LATENCY=3 is supported");
  end
  if ((OUTSTANDING < 2) || ((OUTSTANDING & (OUTSTANDING - 1)) != 0)) begin : g_bad_depth
    $error("om_blend_rmw_ctrl: OUTSTANDING must be a power of 2 and >= 2");
  end

  // Pending FIFO storage
  logic [ADDRW-1:0]       r_ent_addr [OUTSTANDING];
  logic [31:0]            r_ent_src  [OUTSTANDING];
  logic [31:0]            r_ent_dst  [OUTSTANDING];
  logic [OUTSTANDING-1:0] r_ent_rdy;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  // Blend pipeline shadow (address + valid per stage)
  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic [ADDRW-1:0] r_s1_addr,  r_s2_addr,  r_s3_addr;

  logic [OUTSTANDING-1:0] w_ent_valid;
  logic [PW-1:0]          w_off;
  logic [PW-1:0]          w_idx;
  logic                   w_hazard;
  logic                   w_full;
  logic                   w_rsp_hit;
  logic [PW-1:0]          w_rsp_idx;
  logic                   w_head_rdy;
  logic                   w_blend_en;
  logic                   w_push;
  logic                   w_pop;

  // Entry occupancy and address hazard against registered state only
  always_comb begin
    w_ent_valid = {OUTSTANDING{1'b0}};
    w_off       = {PW{1'b0}};
    w_hazard    = 1'b0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      w_off          = PW'(i) - r_head;
      w_ent_valid[i] = ({1'b0, w_off} < r_count);
      if (w_ent_valid[i] && (r_ent_addr[i] == req_addr)) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
    w_hazard = w_hazard
             | (r_s1_valid & (r_s1_addr == req_addr))
             | (r_s2_valid & (r_s2_addr == req_addr))
             | (r_s3_valid & (r_s3_addr == req_addr));
  end

  // Response target: oldest valid entry still waiting for its read data
  always_comb begin
    w_rsp_hit = 1'b0;
    w_rsp_idx = {PW{1'b0}};
    w_idx     = {PW{1'b0}};
    for (int k = 0; k < OUTSTANDING; k++) begin
      w_idx = r_head + PW'(k);
      if (!w_rsp_hit && w_ent_valid[w_idx] && !r_ent_rdy[w_idx]) begin
        w_rsp_hit = 1'b1;
        w_rsp_idx = w_idx;
      end else begin
        w_rsp_hit = w_rsp_hit;
      end
    end
  end

  // Handshakes; everything is forced quiet while reset is low
  assign w_full     = (r_count == LP_FULL);
  assign w_head_rdy = (r_count != LP_CZERO) & r_ent_rdy[r_head];
  assign w_blend_en = reset & ~(r_s3_valid & ~mem_wr_ready);
  assign w_push     = req_valid & req_ready;
  assign w_pop      = w_blend_en & w_head_rdy;

  assign req_ready       = reset & mem_rd_ready & ~w_full & ~w_hazard;
  assign mem_rd_valid    = reset & req_valid & ~w_full & ~w_hazard;
  assign mem_rd_addr     = req_addr;
  assign blend_enable    = w_blend_en;
  assign blend_src_color = r_ent_src[r_head];
  assign blend_dst_color = r_ent_dst[r_head];
  assign mem_wr_valid    = reset & r_s3_valid;
  assign mem_wr_addr     = r_s3_addr;
  assign mem_wr_data     = blend_color_in;
  assign busy            = reset & ((r_count != LP_CZERO) | r_s1_valid | r_s2_valid | r_s3_valid);

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= LP_CZERO;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + LP_PONE;
      end
      if (w_pop) begin
        r_head <= r_head + LP_PONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CONE;
        2'b01:   r_count <= r_count - LP_CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload: address/source on push, destination on response
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_tail] <= req_addr;
      r_ent_src[r_tail]  <= req_color;
    end
    if (reset && mem_rsp_valid && w_rsp_hit) begin
      r_ent_dst[w_rsp_idx] <= mem_rsp_data;
    end
  end

  // Per-entry ready bits; a response with no waiting entry is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ent_rdy <= {OUTSTANDING{1'b0}};
    end else begin
      if (w_push) begin
        r_ent_rdy[r_tail] <= 1'b0;
      end
      if (mem_rsp_valid && w_rsp_hit) begin
        r_ent_rdy[w_rsp_idx] <= 1'b1;
      end
    end
  end

  // Blend pipeline shadow; head enters s1 only once its data is back
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_blend_en) begin
      r_s1_valid <= w_head_rdy;
      r_s1_addr  <= r_ent_addr[r_head];
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_s3_valid <= r_s2_valid;
      r_s3_addr  <= r_s2_addr;
    end
  end

  om_blend_rmw_ctrl_chk #(.CW(CW), .OUTSTANDING(OUTSTANDING)) u_chk (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rsp_valid (mem_rsp_valid),
    .i_rsp_hit   (w_rsp_hit),
    .i_count     (r_count)
  );

endmodule

// ---------------------------------------------------------------------------
// om_blend_rmw_ctrl_chk
//   Protocol checks for om_blend_rmw_ctrl.
// Ports
//   i_clk, i_reset   clock and active-low reset of the controller
//   i_rsp_valid      memory response strobe
//   i_rsp_hit        an entry is waiting for that response
//   i_count          FIFO occupancy
// ---------------------------------------------------------------------------
module om_blend_rmw_ctrl_chk #(
  parameter int CW          = 3,
  parameter int OUTSTANDING = 4
) (
  input logic          i_clk,
  input logic          i_reset,
  input logic          i_rsp_valid,
  input logic          i_rsp_hit,
  input logic [CW-1:0] i_count
);

  // Responses must always have an outstanding read; count must not overflow
  always @(posedge i_clk) begin
    if (i_reset) begin
      a_rsp_has_target: assert (!i_rsp_valid || i_rsp_hit)
        else $error("om_blend_rmw_ctrl: mem_rsp_valid with no outstanding read");
      a_count_bound: assert (i_count <= CW'(OUTSTANDING))
        else $error("om_blend_rmw_ctrl: FIFO count overflow");
    end
  end

endmodule

// File: tb/tb_om_blend_rmw_ctrl.sv
module tb_om_blend_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [23:0] req_addr;
  logic [31:0] req_color;
  logic        req_ready;
  logic        mem_rd_valid;
  logic [23:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        blend_enable;
  logic [31:0] blend_src_color;
  logic [31:0] blend_dst_color;
  logic [31:0] blend_color_in;
  logic        mem_wr_valid;
  logic [23:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        busy;

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] rd_q[$];
  int          n_checks    = 0;
  int          n_pass      = 0;
  int          n_wr        = 0;
  int          rsp_credit  = 1000;
  logic        dst_one     = 1'b0;
  logic [31:0] bl1, bl2, bl3;

  om_blend_rmw_ctrl #(.ADDRW(24), .OUTSTANDING(4), .BLEND_LATENCY(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_color       (req_color),
    .req_ready       (req_ready),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_ready    (mem_rd_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .blend_enable    (blend_enable),
    .blend_src_color (blend_src_color),
    .blend_dst_color (blend_dst_color),
    .blend_color_in  (blend_color_in),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ready    (mem_wr_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Framebuffer contents as seen by the bench
  function automatic logic [31:0] mem_val(input logic [23:0] a);
    return 32'h11223334 + {8'h00, a};
  endfunction

  // Blender: src*ONE + dst*(ONE or ZERO), per-channel saturating add
  function automatic logic [31:0] blend_fn(input logic [31:0] src, input logic [31:0] dst, input logic one);
    logic [31:0] r;
    logic [8:0]  s;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      s = {1'b0, src[8*b +: 8]} + (one ? {1'b0, dst[8*b +: 8]} : 9'd0);
      r[8*b +: 8] = s[8] ? 8'hFF : s[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    step();
    chk(tag, done, 1'b1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // 3-stage blender model advancing on blend_enable
  always @(posedge clk) begin
    if (blend_enable) begin
      bl1 <= blend_fn(blend_src_color, blend_dst_color, dst_one);
      bl2 <= bl1;
      bl3 <= bl2;
    end
  end
  assign blend_color_in = bl3;

  // Memory read responder: in order, one cycle after the read, while credit lasts
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_credit > 0 && rd_q.size() > 0) begin
        mem_rsp_data  = mem_val(rd_q.pop_front());
        mem_rsp_valid = 1'b1;
        rsp_credit--;
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Scoreboard: push on request fire, pop and compare on write fire
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      rd_q.delete();
    end else begin
      if (mem_rd_valid && mem_rd_ready) rd_q.push_back(mem_rd_addr);
      if (req_valid && req_ready) begin
        e.addr = req_addr;
        e.data = blend_fn(req_color, mem_val(req_addr), dst_one);
        exp_q.push_back(e);
      end
      if (mem_wr_valid && mem_wr_ready) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_wr", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_wr_addr", mem_wr_addr, e.addr);
          chk("sb_wr_data", mem_wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          wr0;
    logic        found;
    logic        wf;
    logic        saw;
    logic [31:0] e0;
    logic [31:0] cols [3];

    reset        = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 24'h5;
    req_color    = 32'h0;
    mem_rd_ready = 1'b1;
    mem_wr_ready = 1'b1;

    // ---- reset state ----
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rd_valid", mem_rd_valid, 1'b0);
    chk("rst_wr_valid", mem_wr_valid, 1'b0);
    chk("rst_blend_en", blend_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    reset     = 1'b1;
    req_valid = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_blend_en", blend_enable, 1'b1);
    chk("post_rst_req_ready", req_ready, 1'b1);
    step();

    // ---- single fragment, dst factor ZERO ----
    dst_one   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 24'h10;
    req_color = 32'hFF804020;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 1'b1);
    chk("t1_rd_valid", mem_rd_valid, 1'b1);
    chk("t1_rd_addr", mem_rd_addr, 24'h10);
    step();
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_wr_valid) begin
        lat = k;
        chk("t1_wr_addr", mem_wr_addr, 24'h10);
        chk("t1_wr_data", mem_wr_data, 32'hFF804020);
        break;
      end
      step();
    end
    chk("t1_latency", lat, 5);
    step();
    wait_idle("t1_idle");

    // ---- same-address hazard ----
    dst_one   = 1'b1;
    req_valid = 1'b1;
    req_addr  = 24'h20;
    req_color = 32'h10203040;
    @(negedge clk);
    chk("t2_first_ready", req_ready, 1'b1);
    step();
    req_color = 32'h01020304;
    @(negedge clk);
    chk("t2_haz_ready", req_ready, 1'b0);
    chk("t2_haz_rd_valid", mem_rd_valid, 1'b0);
    step();
    req_addr  = 24'h30;
    req_color = 32'h80808080;
    @(negedge clk);
    chk("t2_other_ready", req_ready, 1'b1);
    step();
    req_addr  = 24'h20;
    req_color = 32'h01020304;
    wf    = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wf) begin
        chk("t2_after_wr_ready", req_ready, 1'b1);
        chk("t2_after_wr_rd_valid", mem_rd_valid, 1'b1);
        found = 1'b1;
        break;
      end else begin
        chk("t2_blocked", req_ready, 1'b0);
        if (mem_wr_valid && mem_wr_ready && mem_wr_addr == 24'h20) wf = 1'b1;
      end
      step();
    end
    chk("t2_released", found, 1'b1);
    step();
    req_valid = 1'b0;
    wait_idle("t2_idle");

    // ---- FIFO full, no responses ----
    @(negedge clk);
    rsp_credit = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 24'h40 + 24'(i);
      req_color = 32'hA0A0A000 + 32'(i);
      @(negedge clk);
      if (i < 4) begin
        chk("t3_accept", req_ready, 1'b1);
      end else begin
        chk("t3_full_ready", req_ready, 1'b0);
        chk("t3_full_rd_valid", mem_rd_valid, 1'b0);
      end
      step();
    end
    @(negedge clk);
    chk("t3_still_full", req_ready, 1'b0);
    rsp_credit = 1;
    step();
    @(negedge clk);
    chk("t3_wait_rsp", req_ready, 1'b0);
    step();
    @(negedge clk);
    chk("t3_wait_pop", req_ready, 1'b0);
    step();
    @(negedge clk);
    chk("t3_fifth_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    rsp_credit = 1000;
    step();
    wait_idle("t3_idle");

    // ---- write backpressure ----
    cols[0] = 32'h0F0F0F0F;
    cols[1] = 32'h70707070;
    cols[2] = 32'hF0F0F0F0;
    e0  = blend_fn(cols[0], mem_val(24'h50), 1'b1);
    wr0 = n_wr;
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 24'h50 + 24'(i);
      req_color = cols[i];
      @(negedge clk);
      chk("t4_accept", req_ready, 1'b1);
      step();
    end
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_wr_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t4_wr_valid_seen", found, 1'b1);
    for (int j = 0; j < 5; j++) begin
      chk("t4_stall_blend_en", blend_enable, 1'b0);
      chk("t4_stall_wr_addr", mem_wr_addr, 24'h50);
      chk("t4_stall_wr_data", mem_wr_data, e0);
      step();
      if (j < 4) @(negedge clk);
    end
    mem_wr_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_write_count", n_wr - wr0, 3);

    // ---- reset mid-operation ----
    @(negedge clk);
    rsp_credit = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 24'h60 + 24'(i);
      req_color = 32'h12345678;
      @(negedge clk);
      chk("t5_accept", req_ready, 1'b1);
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre_busy", busy, 1'b1);
    step();
    reset = 1'b0;
    wr0   = n_wr;
    @(negedge clk);
    chk("t5_in_rst_busy", busy, 1'b0);
    chk("t5_in_rst_blend_en", blend_enable, 1'b0);
    chk("t5_in_rst_wr_valid", mem_wr_valid, 1'b0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_after_busy", busy, 1'b0);
    chk("t5_after_wr_valid", mem_wr_valid, 1'b0);
    chk("t5_after_rd_valid", mem_rd_valid, 1'b0);
    step();
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_wr_valid) saw = 1'b1;
      step();
    end
    chk("t5_no_writeback", saw, 1'b0);
    chk("t5_write_count", n_wr - wr0, 0);
    @(negedge clk);
    rsp_credit = 1000;
    step();
    req_valid = 1'b1;
    req_addr  = 24'h70;
    req_color = 32'h00FF00FF;
    @(negedge clk);
    chk("t5_new_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    wait_idle("t5_idle");
    chk("t5_new_write_count", n_wr - wr0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/om_blend_rmw_ctrl.md
Name: om_blend_rmw_ctrl

Overview:
- Read-modify-write front end for the OM blender; drives the blender inputs and consumes its output.
- Accepts fragments (address, source colour) and issues framebuffer reads for the destination colour.
- Feeds source/destination pairs to the 3-cycle blend multiply-add stage and writes the blended result back to memory.
- Guarantees RMW ordering per address by stalling requests that hit an in-flight address.

Parameters:
- ADDRW, 24: framebuffer word address width.
- OUTSTANDING, 4: max reads issued and not yet entered into blend pipeline; power of 2, ≥2.
- BLEND_LATENCY, 3: blender latency in enabled cycles; only 3 supported (static assert).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  1  fragment request valid
- req_addr  in  ADDRW  fragment address
- req_color  in  32  source colour (ARGB8888)
- req_ready  out  1  request accepted when req_valid & req_ready
- mem_rd_valid  out  1  read request valid
- mem_rd_addr  out  ADDRW  read address
- mem_rd_ready  in  1  read request accepted
- mem_rsp_valid  in  1  read data valid; in order, no backpressure
- mem_rsp_data  in  32  destination colour
- blend_enable  out  1  blender pipeline advance
- blend_src_color  out  32  to blender src_color
- blend_dst_color  out  32  to blender dst_color
- blend_color_in  in  32  from blender color_out
- mem_wr_valid  out  1  write-back valid
- mem_wr_addr  out  ADDRW  write-back address
- mem_wr_data  out  32  write-back data
- mem_wr_ready  in  1  write-back accepted
- busy  out  1  any entry or pipeline stage valid

Behaviour:
- Reset (reset=0 at edge): clears FIFO pointers/count, entry ready bits, and pipeline valid bits. While reset=0, req_ready, mem_rd_valid, mem_wr_valid, blend_enable and busy are all 0. Reset mid-operation drops all in-flight work with no write-back. Late mem_rsp after reset is ignored.
- Pending FIFO: OUTSTANDING entries of {addr, src_color, dst_color, rdy}.
- full = (count == OUTSTANDING).
- hazard = req_addr matches any valid FIFO entry or any valid pipeline stage (s1..s3), compared on current registered state.
- Read issue is combinational pass-through:
  - mem_rd_valid = req_valid & !full & !hazard
  - mem_rd_addr = req_addr
  - req_ready = mem_rd_ready & !full & !hazard
  - On fire, push {req_addr, req_color, rdy=0} at the tail.
- Response: mem_rsp_valid writes mem_rsp_data into the oldest entry with rdy=0 and sets its rdy. mem_rsp_valid with no such entry is a protocol error (assertion).
- blend_enable = !(s3_valid & !mem_wr_ready).
- blend_src_color and blend_dst_color are driven from the FIFO head every cycle.
- When blend_enable=1:
  - s1 <= {head rdy, head addr}; pop the head if rdy, otherwise insert a bubble (s1_valid=0).
  - s2 <= s1; s3 <= s2.
- When blend_enable=0: s1..s3 and the head hold. Responses are still captured.
- Output:
  - mem_wr_valid = s3_valid; mem_wr_addr = s3_addr; mem_wr_data = blend_color_in.
  - The s3 slot frees on write fire.
- Latency: response captured at edge ending cycle N → head presented with blend_enable=1 in N+1 → mem_wr_valid in N+4 (no stalls). Issue to write-back = memory latency + 4.
- Ordering: write-backs occur in request order. A same-address request is accepted no earlier than the cycle after its predecessor's write fire.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Response to the head entry in the same cycle it would enter: enters next cycle.
  - Write fire and same-address request in the same cycle: still hazard (conservative).
- Full: count saturates at OUTSTANDING; req_ready=0 until a pop.
- busy = count≠0 | s1_valid | s2_valid | s3_valid.

Test Plan:
- Single fragment (blender factors src=0xFFFFFFFF, dst=0, mode ADD): req addr 0x10, color 0xFF804020; rsp 0x11223344 one cycle after read.
  - Expect mem_wr addr 0x10, data 0xFF804020, in cycle rsp+4.
- Hazard: back-to-back reqs to 0x20.
  - Expect second req_ready=0 until first mem_wr fires; second mem_rd_valid in the following cycle.
  - Different-address req in between is accepted immediately.
- Full: 5 distinct reqs, no responses.
  - Expect first 4 accepted, 5th held with req_ready=0.
  - One rsp plus head pop → 5th accepted next cycle.
- Write backpressure: 3 fragments in pipeline, mem_wr_ready=0 for 5 cycles.
  - Expect blend_enable=0 throughout, mem_wr_data stable.
  - After release, 3 writes in order with correct data, none lost or duplicated.
- Reset mid-op: 2 entries outstanding, 1 in s2, assert reset=0 one cycle.
  - Expect busy=0, all valids 0 next cycle, no write-back.
  - New req accepted normally after reset=1.
